// File: rtl/split_two_outputs_pkg.sv
// Shared definitions for the fan-out stage: default sample width and split mode.
package split_two_outputs_pkg;

    localparam int SPLIT_DATA_WIDTH = 32;

    typedef enum logic {
        SPLIT_BCAST = 1'b0,
        SPLIT_DEINT = 1'b1
    } split_mode_t;

endpackage

// File: rtl/split_two_outputs_out_lane.sv
// One downstream branch: remembers an owed write and issues it only while the FIFO has room.
module split_out_lane
    import split_two_outputs_pkg::*;
#(
    parameter int DATA_WIDTH = SPLIT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  set,
    input  logic                  clr,
    input  logic                  full,
    input  logic [DATA_WIDTH-1:0] hold,
    output logic                  wr_en,
    output logic                  pend,
    output logic [DATA_WIDTH-1:0] din
);

    logic pend_q;
    logic pend_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        wr_en  = en & pend_q & ~full;
        din    = wr_en ? hold : '0;
        pend_d = pend_q;
        if (clr) begin
            pend_d = 1'b0;
        end else if (set) begin
            pend_d = 1'b1;
        end else if (wr_en) begin
            pend_d = 1'b0;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/split_two_outputs.sv
// Fan-out stage: pops one sample from upstream and delivers it to FIFO A and/or B,
// either broadcasting every sample or deinterleaving even/odd samples.
module split_two_outputs
    import split_two_outputs_pkg::*;
#(
    parameter int DATA_WIDTH = SPLIT_DATA_WIDTH,
    parameter int MODE       = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  outA_wr_en,
    input  logic                  outA_full,
    output logic [DATA_WIDTH-1:0] outA_din,
    output logic                  outB_wr_en,
    input  logic                  outB_full,
    output logic [DATA_WIDTH-1:0] outB_din
);

    typedef enum logic [1:0] {
        S_READ  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    localparam split_mode_t SPLIT_MODE = (MODE == 1) ? SPLIT_DEINT : SPLIT_BCAST;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  sel_q, sel_d;
    logic                  set_a, set_b, clr_pend;
    logic                  write_phase;
    logic                  pend_a, pend_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_READ;
            hold_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    // A branch that owes nothing counts as done, so one stalled branch never blocks the other.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        sel_d    = sel_q;
        set_a    = 1'b0;
        set_b    = 1'b0;
        clr_pend = 1'b0;
        case (state_q)
            S_READ: begin
                if (!in_empty) begin
                    hold_d  = in_dout;
                    state_d = S_WRITE;
                    if (SPLIT_MODE == SPLIT_DEINT) begin
                        set_a = ~sel_q;
                        set_b = sel_q;
                        sel_d = ~sel_q;
                    end else begin
                        set_a = 1'b1;
                        set_b = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if ((!pend_a || outA_wr_en) && (!pend_b || outB_wr_en)) begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d  = S_READ;
                clr_pend = 1'b1;
            end
        endcase
    end

    always_comb begin
        write_phase = (state_q == S_WRITE);
        in_rd_en    = (state_q == S_READ) && !in_empty && !reset;
    end

    split_out_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_a (
        .clock (clock),
        .reset (reset),
        .en    (write_phase),
        .set   (set_a),
        .clr   (clr_pend),
        .full  (outA_full),
        .hold  (hold_q),
        .wr_en (outA_wr_en),
        .pend  (pend_a),
        .din   (outA_din)
    );

    split_out_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_b (
        .clock (clock),
        .reset (reset),
        .en    (write_phase),
        .set   (set_b),
        .clr   (clr_pend),
        .full  (outB_full),
        .hold  (hold_q),
        .wr_en (outB_wr_en),
        .pend  (pend_b),
        .din   (outB_din)
    );

endmodule

// File: tb/tb_split_two_outputs.sv
// Bench for split_two_outputs: a broadcast and a deinterleave instance fed from emulated
// FIFOs, checked every cycle against a stream-level model of what each branch must receive.
module tb_split_two_outputs;

   localparam int DW    = 32;
   localparam int DEPTH = 4096;
   localparam int LOGN  = 64;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic          inRdEn[2];
   logic          inEmpty[2];
   logic [DW-1:0] inDout[2];
   logic          outAWrEn[2];
   logic          outAFull[2];
   logic [DW-1:0] outADin[2];
   logic          outBWrEn[2];
   logic          outBFull[2];
   logic [DW-1:0] outBDin[2];

   // Upstream FIFO contents and the per-branch streams still owed by the DUT
   logic [DW-1:0] srcMem[2][DEPTH];
   int            srcHead[2], srcTail[2];
   logic [DW-1:0] expA[2][DEPTH];
   int            expAHead[2], expATail[2];
   logic [DW-1:0] expB[2][DEPTH];
   int            expBHead[2], expBTail[2];
   int            popCount[2];

   int            popCyc[2][LOGN];
   int            nPop[2];
   int            wrACyc[2][LOGN];
   logic [DW-1:0] gotA[2][LOGN];
   int            nWrA[2];
   int            wrBCyc[2][LOGN];
   logic [DW-1:0] gotB[2][LOGN];
   int            nWrB[2];

   int emptyPct[2], fullAPct[2], fullBPct[2];
   bit holdFullA[2], holdFullB[2];

   int cyc = 0;
   int total = 0;
   int bad = 0;

   always @(posedge clock) cyc <= cyc + 1;

   split_two_outputs #(.DATA_WIDTH(DW), .MODE(0)) dutBcast (
      .clock(clock), .reset(reset),
      .in_rd_en(inRdEn[0]), .in_empty(inEmpty[0]), .in_dout(inDout[0]),
      .outA_wr_en(outAWrEn[0]), .outA_full(outAFull[0]), .outA_din(outADin[0]),
      .outB_wr_en(outBWrEn[0]), .outB_full(outBFull[0]), .outB_din(outBDin[0])
   );

   split_two_outputs #(.DATA_WIDTH(DW), .MODE(1)) dutDeint (
      .clock(clock), .reset(reset),
      .in_rd_en(inRdEn[1]), .in_empty(inEmpty[1]), .in_dout(inDout[1]),
      .outA_wr_en(outAWrEn[1]), .outA_full(outAFull[1]), .outA_din(outADin[1]),
      .outB_wr_en(outBWrEn[1]), .outB_full(outBFull[1]), .outB_din(outBDin[1])
   );

   // Every comparison funnels through here so the summary counts are the real ones
   function automatic void chk(input bit ok, input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
      end
   endfunction

   // Queue one sample into the emulated upstream FIFO of instance k
   task automatic applyStimulus(input int k, input logic [DW-1:0] v);
      srcMem[k][srcTail[k]] = v;
      srcTail[k]++;
   endtask

   // Present FIFO flags/data just after each rising edge, honouring the random knobs
   task automatic driveInputs();
      for (int k = 0; k < 2; k++) begin
         inEmpty[k]  = (srcHead[k] == srcTail[k]) || (int'($urandom_range(99)) < emptyPct[k]);
         inDout[k]   = inEmpty[k] ? $urandom : srcMem[k][srcHead[k]];
         outAFull[k] = holdFullA[k] || (int'($urandom_range(99)) < fullAPct[k]);
         outBFull[k] = holdFullB[k] || (int'($urandom_range(99)) < fullBPct[k]);
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         driveInputs();
      end
   end

   // Model: each pop appends the sample to the stream(s) it belongs to; each write must
   // take the oldest owed sample of that stream; a new pop is only legal once nothing is owed.
   task automatic checkOutput(input int k);
      logic [DW-1:0] v;
      if (reset) begin
         chk(!inRdEn[k] && !outAWrEn[k] && !outBWrEn[k], "reset_enables_low",
             {29'd0, inRdEn[k], outAWrEn[k], outBWrEn[k]}, '0);
         chk((outADin[k] | outBDin[k]) == '0, "reset_din_zero", outADin[k] | outBDin[k], '0);
         expAHead[k] = expATail[k];
         expBHead[k] = expBTail[k];
         popCount[k] = 0;
      end else begin
         chk(!(outAWrEn[k] && outAFull[k]), "wrA_while_full", {31'd0, outAWrEn[k]}, '0);
         chk(!(outBWrEn[k] && outBFull[k]), "wrB_while_full", {31'd0, outBWrEn[k]}, '0);
         chk(outAWrEn[k] || outADin[k] == '0, "dinA_idle_zero", outADin[k], '0);
         chk(outBWrEn[k] || outBDin[k] == '0, "dinB_idle_zero", outBDin[k], '0);
         chk(!(inRdEn[k] && inEmpty[k]), "pop_while_empty", {31'd0, inRdEn[k]}, '0);
         if (k == 1) chk(!(outAWrEn[k] && outBWrEn[k]), "deint_both_written", 32'd1, '0);
         if (outAWrEn[k]) begin
            chk(expAHead[k] != expATail[k], "wrA_unexpected", outADin[k], '0);
            if (expAHead[k] != expATail[k]) begin
               chk(outADin[k] == expA[k][expAHead[k]], "dinA_data", outADin[k], expA[k][expAHead[k]]);
               expAHead[k]++;
            end
            if (nWrA[k] < LOGN) begin
               wrACyc[k][nWrA[k]] = cyc;
               gotA[k][nWrA[k]]   = outADin[k];
            end
            nWrA[k]++;
         end
         if (outBWrEn[k]) begin
            chk(expBHead[k] != expBTail[k], "wrB_unexpected", outBDin[k], '0);
            if (expBHead[k] != expBTail[k]) begin
               chk(outBDin[k] == expB[k][expBHead[k]], "dinB_data", outBDin[k], expB[k][expBHead[k]]);
               expBHead[k]++;
            end
            if (nWrB[k] < LOGN) begin
               wrBCyc[k][nWrB[k]] = cyc;
               gotB[k][nWrB[k]]   = outBDin[k];
            end
            nWrB[k]++;
         end
         if (inRdEn[k] && !inEmpty[k]) begin
            chk(expAHead[k] == expATail[k] && expBHead[k] == expBTail[k], "pop_while_owed",
                (expATail[k] - expAHead[k]) + (expBTail[k] - expBHead[k]), '0);
            v = srcMem[k][srcHead[k]];
            srcHead[k]++;
            if (k == 0 || popCount[k] % 2 == 0) begin
               expA[k][expATail[k]] = v;
               expATail[k]++;
            end
            if (k == 0 || popCount[k] % 2 == 1) begin
               expB[k][expBTail[k]] = v;
               expBTail[k]++;
            end
            popCount[k]++;
            if (nPop[k] < LOGN) popCyc[k][nPop[k]] = cyc;
            nPop[k]++;
         end
      end
   endtask

   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) checkOutput(k);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #3;
   endtask

   task automatic clearLogs();
      for (int k = 0; k < 2; k++) begin
         nPop[k] = 0;
         nWrA[k] = 0;
         nWrB[k] = 0;
      end
   endtask

   task automatic waitDrain(input int k, input int bound, input string name);
      int c;
      c = 0;
      while (!(srcHead[k] == srcTail[k] && expAHead[k] == expATail[k] &&
               expBHead[k] == expBTail[k]) && c < bound) begin
         tick(1);
         c++;
      end
      chk(c < bound, name, c, bound);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL global_timeout: got=%0t want=finished", $time);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [DW-1:0] seq1[3];
      seq1[0] = 32'd5;
      seq1[1] = 32'hFFFF_FFF9;
      seq1[2] = 32'h7FFF_FFFF;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         inEmpty[k] = 1'b1; inDout[k] = '0; outAFull[k] = 1'b0; outBFull[k] = 1'b0;
         srcHead[k] = 0; srcTail[k] = 0; expAHead[k] = 0; expATail[k] = 0;
         expBHead[k] = 0; expBTail[k] = 0; popCount[k] = 0;
         emptyPct[k] = 0; fullAPct[k] = 0; fullBPct[k] = 0;
         holdFullA[k] = 1'b0; holdFullB[k] = 1'b0;
      end
      clearLogs();
      tick(3);
      reset = 1'b0;
      tick(1);

      $display("[TB] broadcast of 5, -7, max positive");
      clearLogs();
      for (int i = 0; i < 3; i++) applyStimulus(0, seq1[i]);
      waitDrain(0, 50, "t1_drain");
      chk(nWrA[0] == 3, "t1_countA", nWrA[0], 3);
      chk(nWrB[0] == 3, "t1_countB", nWrB[0], 3);
      for (int i = 0; i < 3; i++) begin
         chk(gotA[0][i] == seq1[i], "t1_dataA", gotA[0][i], seq1[i]);
         chk(gotB[0][i] == seq1[i], "t1_dataB", gotB[0][i], seq1[i]);
      end
      chk(popCyc[0][1] - popCyc[0][0] == 2, "t1_pop_spacing", popCyc[0][1] - popCyc[0][0], 2);
      chk(popCyc[0][2] - popCyc[0][1] == 2, "t1_pop_spacing2", popCyc[0][2] - popCyc[0][1], 2);
      chk(wrACyc[0][0] == popCyc[0][0] + 1, "t1_latency", wrACyc[0][0] - popCyc[0][0], 1);

      $display("[TB] deinterleave of 1..6");
      clearLogs();
      for (int i = 1; i <= 6; i++) applyStimulus(1, i);
      waitDrain(1, 60, "t2_drain");
      chk(nWrA[1] == 3 && nWrB[1] == 3, "t2_counts", nWrA[1] * 16 + nWrB[1], 8'h33);
      for (int i = 0; i < 3; i++) begin
         chk(gotA[1][i] == 2 * i + 1, "t2_dataA", gotA[1][i], 2 * i + 1);
         chk(gotB[1][i] == 2 * i + 2, "t2_dataB", gotB[1][i], 2 * i + 2);
      end

      $display("[TB] deinterleave with A stalled on most negative sample");
      clearLogs();
      holdFullA[1] = 1'b1;
      applyStimulus(1, 32'h8000_0000);
      applyStimulus(1, 32'd9);
      tick(10);
      chk(nPop[1] == 1, "t6_no_pop_during_stall", nPop[1], 1);
      chk(nWrA[1] == 0, "t6_no_write_while_full", nWrA[1], 0);
      holdFullA[1] = 1'b0;
      waitDrain(1, 40, "t6_drain");
      chk(gotA[1][0] == 32'h8000_0000, "t6_dataA", gotA[1][0], 32'h8000_0000);
      chk(gotB[1][0] == 32'd9, "t6_dataB", gotB[1][0], 32'd9);
      chk(popCyc[1][1] > wrACyc[1][0], "t6_pop_after_A", popCyc[1][1], wrACyc[1][0] + 1);

      $display("[TB] broadcast with A full for 10 cycles");
      clearLogs();
      holdFullA[0] = 1'b1;
      applyStimulus(0, 32'd42);
      applyStimulus(0, 32'd43);
      tick(10);
      chk(nPop[0] == 1, "t3_no_pop_during_stall", nPop[0], 1);
      chk(nWrB[0] == 1 && gotB[0][0] == 32'd42, "t3_B_written", gotB[0][0], 32'd42);
      chk(wrBCyc[0][0] == popCyc[0][0] + 1, "t3_B_latency", wrBCyc[0][0] - popCyc[0][0], 1);
      chk(nWrA[0] == 0, "t3_A_held", nWrA[0], 0);
      holdFullA[0] = 1'b0;
      waitDrain(0, 40, "t3_drain");
      chk(nWrA[0] == 2, "t3_A_once_each", nWrA[0], 2);
      chk(gotA[0][0] == 32'd42 && gotA[0][1] == 32'd43, "t3_dataA", gotA[0][0], 32'd42);

      $display("[TB] reset while A write is owed");
      clearLogs();
      holdFullA[1] = 1'b1;
      applyStimulus(1, 32'd11);
      tick(3);
      chk(nPop[1] == 1, "t5_popped", nPop[1], 1);
      holdFullA[1] = 1'b0;
      outAFull[1] = 1'b0;
      #1;
      chk(outAWrEn[1] == 1'b1 && outADin[1] == 32'd11, "t5_write_armed", outADin[1], 32'd11);
      reset = 1'b1;
      #1;
      chk(outAWrEn[1] == 1'b0, "t5_async_wr_low", {31'd0, outAWrEn[1]}, '0);
      chk(outADin[1] == '0, "t5_async_din_zero", outADin[1], '0);
      tick(2);
      reset = 1'b0;
      tick(3);
      chk(nWrA[1] == 0, "t5_no_stale_write", nWrA[1], 0);
      applyStimulus(1, 32'd21);
      applyStimulus(1, 32'd22);
      waitDrain(1, 40, "t5_drain");
      chk(gotA[1][0] == 32'd21, "t5_parity_restart_A", gotA[1][0], 32'd21);
      chk(gotB[1][0] == 32'd22, "t5_parity_restart_B", gotB[1][0], 32'd22);

      $display("[TB] random empty/full traffic on both instances");
      clearLogs();
      for (int k = 0; k < 2; k++) begin
         emptyPct[k] = 30; fullAPct[k] = 30; fullBPct[k] = 30;
      end
      for (int i = 0; i < 1000; i++) applyStimulus(0, $urandom);
      for (int i = 0; i < 600; i++) applyStimulus(1, $urandom);
      waitDrain(0, 20000, "t4_drain_bcast");
      waitDrain(1, 20000, "t4_drain_deint");
      for (int k = 0; k < 2; k++) begin
         emptyPct[k] = 0; fullAPct[k] = 0; fullBPct[k] = 0;
      end
      chk(nPop[0] == 1000, "t4_pops_bcast", nPop[0], 1000);
      chk(nWrA[0] == 1000 && nWrB[0] == 1000, "t4_writes_bcast", nWrA[0] + nWrB[0], 2000);
      chk(nWrA[1] == 300 && nWrB[1] == 300, "t4_writes_deint", nWrA[1] + nWrB[1], 600);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
